// File: rtl/gry_bin_sync_if.sv
// Pointer-crossing bundle between the FIFO control logic and gry_bin_sync.
// master: drives gry_in/loc_bin, observes status; slave: the synchronizer.
interface gry_bin_sync_if #(
    parameter int P_NUM_BITS = 8
);
    logic [P_NUM_BITS-1:0] gry_in;
    logic [P_NUM_BITS-1:0] loc_bin;
    logic [P_NUM_BITS-1:0] gry_sync;
    logic [P_NUM_BITS-1:0] bin_out;
    logic [P_NUM_BITS-1:0] delta;
    logic [P_NUM_BITS-1:0] occ;
    logic                  upd;
    logic                  empty;
    logic                  full;
    logic                  gry_err;

    modport master (
        output gry_in, loc_bin,
        input  gry_sync, bin_out, delta, occ,
        input  upd, empty, full, gry_err
    );

    modport slave (
        input  gry_in, loc_bin,
        output gry_sync, bin_out, delta, occ,
        output upd, empty, full, gry_err
    );
endinterface

// File: rtl/gry_bin_sync.sv
// Receive side of an async FIFO gray pointer crossing: sync, decode, occupancy.
// Ports: clk, rst_n (sync, active-low), bus (slave). Optional GRY_SYNC_CHK_EN.
module gry_bin_sync #(
    parameter int P_NUM_BITS    = 8,
    parameter int P_SYNC_STAGES = 2,
    parameter int P_LOCAL_WR    = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    gry_bin_sync_if.slave  bus
);
    localparam int W = P_NUM_BITS;
    localparam int S = P_SYNC_STAGES;
    localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

    logic [W-1:0] stg [S];
    logic [W-1:0] dec_bin;
    logic [W-1:0] bin_q;
    logic [W-1:0] delta_q;
    logic         upd_q;
    logic [W-1:0] occ_c;
    logic         err_q;

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Plain flop chain: no logic between stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < S; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= bus.gry_in;
            for (int i = 1; i < S; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    assign dec_bin = g2b(stg[S-1]);

    // delta only moves when the pointer does, so it keeps the last step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q   <= '0;
            delta_q <= '0;
            upd_q   <= 1'b0;
        end else begin
            bin_q <= dec_bin;
            upd_q <= (dec_bin != bin_q);
            if (dec_bin != bin_q) begin
                delta_q <= dec_bin - bin_q;
            end
        end
    end

    // Modular subtraction absorbs pointer wrap on either side.
    always_comb begin
        occ_c = '0;
        if (P_LOCAL_WR != 0) begin
            occ_c = bus.loc_bin - bin_q;
        end else begin
            occ_c = bin_q - bus.loc_bin;
        end
    end

`ifdef GRY_SYNC_CHK_EN
    localparam int LIM = S + 1;

    logic [2:0] arm_cnt;
    logic       armed;
    logic [W-1:0] step;

    function automatic int unsigned popcnt(input logic [W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < W; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    // Refill after reset legitimately jumps by many bits; ignore it.
    assign armed = (arm_cnt == 3'(LIM));
    assign step  = stg[S-2] ^ stg[S-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            arm_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (!armed) begin
                arm_cnt <= arm_cnt + 3'd1;
            end
            if (armed && (popcnt(step) > 1)) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign err_q = 1'b0;
`endif

    assign bus.gry_sync = stg[S-1];
    assign bus.bin_out  = bin_q;
    assign bus.delta    = delta_q;
    assign bus.upd      = upd_q;
    assign bus.occ      = occ_c;
    assign bus.empty    = (occ_c == '0);
    assign bus.full     = (occ_c == HALF);
    assign bus.gry_err  = err_q;

endmodule

// File: tb/tb_gry_bin_sync.sv
// Directed bench for gry_bin_sync at P_NUM_BITS=4, both local-pointer roles.
// dut_a: read-domain instance (P_LOCAL_WR=0); dut_b: write-domain instance.
module tb_gry_bin_sync;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

`ifdef GRY_SYNC_CHK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    gry_bin_sync_if #(.P_NUM_BITS(4)) bus_a ();
    gry_bin_sync_if #(.P_NUM_BITS(4)) bus_b ();

    gry_bin_sync #(
        .P_NUM_BITS(4), .P_SYNC_STAGES(2), .P_LOCAL_WR(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );

    gry_bin_sync #(
        .P_NUM_BITS(4), .P_SYNC_STAGES(2), .P_LOCAL_WR(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_g(input logic [3:0] g);
        bus_a.gry_in = g;
        bus_b.gry_in = g;
    endtask

    // Reset with the given inputs, release, then let the sync chain refill.
    task automatic rst_fill(input logic [3:0] g, input logic [3:0] la,
                            input logic [3:0] lb);
        rst_n = 1'b0;
        set_g(g);
        bus_a.loc_bin = la;
        bus_b.loc_bin = lb;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    function automatic logic [3:0] gray(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        set_g(4'b1110);
        bus_a.loc_bin = 4'd0;
        bus_b.loc_bin = 4'd0;

        // Reset state and 3-edge latency.
        tick();
        tick();
        check("rst_bin", int'(bus_a.bin_out), 0);
        check("rst_gsync", int'(bus_a.gry_sync), 0);
        check("rst_occ", int'(bus_a.occ), 0);
        check("rst_empty", int'(bus_a.empty), 1);
        check("rst_full", int'(bus_a.full), 0);
        check("rst_upd", int'(bus_a.upd), 0);
        check("rst_delta", int'(bus_a.delta), 0);
        check("rst_err", int'(bus_a.gry_err), 0);
        rst_n = 1'b1;
        tick();
        check("lat_e1_bin", int'(bus_a.bin_out), 0);
        tick();
        check("lat_e2_gsync", int'(bus_a.gry_sync), 14);
        check("lat_e2_bin", int'(bus_a.bin_out), 0);
        check("lat_e2_upd", int'(bus_a.upd), 0);
        tick();
        check("lat_e3_bin", int'(bus_a.bin_out), 11);
        check("lat_e3_upd", int'(bus_a.upd), 1);
        check("lat_e3_delta", int'(bus_a.delta), 11);
        tick();
        check("lat_e4_upd", int'(bus_a.upd), 0);
        check("lat_e4_delta", int'(bus_a.delta), 11);
        check("lat_err", int'(bus_a.gry_err), 0);

        // Gray walk 0..15 then 0.
        rst_fill(4'b0000, 4'd0, 4'd0);
        check("walk_start", int'(bus_a.bin_out), 0);
        for (int e = 1; e <= 18; e++) begin
            if (e <= 16) set_g(gray(e % 16));
            tick();
            if (e >= 3) begin
                check($sformatf("walk_bin%0d", e), int'(bus_a.bin_out),
                      (e - 2) % 16);
                check($sformatf("walk_upd%0d", e), int'(bus_a.upd), 1);
                check($sformatf("walk_dlt%0d", e), int'(bus_a.delta), 1);
            end
        end
        check("walk_err", int'(bus_a.gry_err), 0);

        // Write side full, released late by the crossing.
        rst_fill(4'b0000, 4'd0, 4'd8);
        check("full_occ", int'(bus_b.occ), 8);
        check("full_flag", int'(bus_b.full), 1);
        check("full_empty", int'(bus_b.empty), 0);
        set_g(4'b0001);
        tick();
        check("full_e1", int'(bus_b.full), 1);
        tick();
        check("full_e2", int'(bus_b.full), 1);
        tick();
        check("full_e3", int'(bus_b.full), 0);
        check("full_e3_occ", int'(bus_b.occ), 7);

        // Read side occupancy across loc_bin wrap.
        rst_fill(4'b0011, 4'd14, 4'd0);
        check("wrap_bin", int'(bus_a.bin_out), 2);
        check("wrap_occ14", int'(bus_a.occ), 4);
        check("wrap_empty14", int'(bus_a.empty), 0);
        bus_a.loc_bin = 4'd15;
        #1 check("wrap_occ15", int'(bus_a.occ), 3);
        bus_a.loc_bin = 4'd0;
        #1 check("wrap_occ0", int'(bus_a.occ), 2);
        bus_a.loc_bin = 4'd1;
        #1 check("wrap_occ1", int'(bus_a.occ), 1);
        check("wrap_empty1", int'(bus_a.empty), 0);
        bus_a.loc_bin = 4'd2;
        #1 check("wrap_occ2", int'(bus_a.occ), 0);
        check("wrap_empty2", int'(bus_a.empty), 1);

        // Two-bit gray jump 3 -> 5.
        rst_fill(4'b0010, 4'd0, 4'd0);
        check("skip_start", int'(bus_a.bin_out), 3);
        set_g(4'b0111);
        tick();
        tick();
        check("skip_e2_upd", int'(bus_a.upd), 0);
        tick();
        check("skip_bin", int'(bus_a.bin_out), 5);
        check("skip_upd", int'(bus_a.upd), 1);
        check("skip_delta", int'(bus_a.delta), 2);
        check("skip_err", int'(bus_a.gry_err), int'(ERR_EXP));
        tick();
        check("skip_upd_off", int'(bus_a.upd), 0);
        check("skip_delta_hold", int'(bus_a.delta), 2);
        set_g(4'b0110);
        repeat (4) tick();
        check("skip_legal_bin", int'(bus_a.bin_out), 4);
        check("skip_sticky", int'(bus_a.gry_err), int'(ERR_EXP));
        rst_n = 1'b0;
        tick();
        check("skip_err_clr", int'(bus_a.gry_err), 0);

        // Mid-run reset while bin_out = 9.
        rst_fill(gray(9), 4'd0, 4'd0);
        check("mid_bin9", int'(bus_a.bin_out), 9);
        rst_n = 1'b0;
        tick();
        check("mid_rst_bin", int'(bus_a.bin_out), 0);
        check("mid_rst_delta", int'(bus_a.delta), 0);
        check("mid_rst_err", int'(bus_a.gry_err), 0);
        rst_n = 1'b1;
        tick();
        tick();
        check("mid_e2_bin", int'(bus_a.bin_out), 0);
        tick();
        check("mid_e3_bin", int'(bus_a.bin_out), 9);
        check("mid_e3_delta", int'(bus_a.delta), 9);
        repeat (3) tick();
        check("mid_err", int'(bus_a.gry_err), 0);
        check("mid_err_b", int'(bus_b.gry_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
